spine_hit: RTL and testbench
============================

# spine_hit

Collision and damage stage downstream of the spine mover. Once per frame it compares the spine's horizontal position against Mario's bounding box and requires the overlap to persist for a set number of frames. When a hit is confirmed it emits a one-cycle hit pulse, decrements the life counter, and then holds an invulnerability window. When the last life is lost it latches game-over until reset.

## Interface
Parameters:
- SPINE_W, 20: spine width in pixels (one brick).
- SPINE_TOP_Y, 440: y of the spine's top edge; the spine runs along the floor.
- MARIO_W, 20: Mario's bounding-box width and height.
- HIT_FRAMES, 2: consecutive overlapping frames needed to confirm a hit; range 1..15.
- INVULN_FRAMES, 60: frames of invulnerability after a non-fatal hit; range 1..255.
- LIVES_INIT, 3: lives at reset; range 1..7.

Ports:
- Clk, in, 1: system clock.
- Reset, in, 1: synchronous, active-high reset.
- frame_tick, in, 1: one-cycle pulse per video frame; all sampling happens only on it.
- spine_x, in, 10: spine left x from the spine mover; 0 means the spine is inactive.
- mario_x, in, 10: Mario's top-left x.
- mario_y, in, 10: Mario's top-left y.
- hit, out, 1: one-cycle pulse when a hit is confirmed.
- invuln, out, 1: high during the invulnerability window.
- lives, out, 3: remaining lives.
- dead, out, 1: game-over flag, sticky until Reset.

## Operation
- Overlap term, combinational. All sums use 11-bit zero-extension, so there is no wrap. The term is true when all of the following hold:
  - spine_x != 0
  - mario_x < spine_x + SPINE_W
  - spine_x < mario_x + MARIO_W
  - mario_y + MARIO_W > SPINE_TOP_Y
- Edges touching exactly do not count as overlap.
- State machine states: ARMED, COUNT, INVULN, OVER.
- Internal registers: ovl_cnt (4 bits), inv_timer (8 bits).
- ARMED, on frame_tick with overlap:
  - If HIT_FRAMES == 1, take the hit.
  - Otherwise set ovl_cnt = 1 and go to COUNT.
- COUNT, on frame_tick:
  - Overlap and ovl_cnt + 1 == HIT_FRAMES: take the hit.
  - Overlap otherwise: ovl_cnt++.
  - No overlap: ovl_cnt = 0 and go to ARMED.
- Taking a hit, all at one edge:
  - hit <= 1, lives <= lives - 1, ovl_cnt <= 0.
  - If lives was 1: dead <= 1 and go to OVER.
  - Otherwise: inv_timer <= INVULN_FRAMES, invuln <= 1, go to INVULN.
- INVULN, on frame_tick:
  - inv_timer--.
  - When inv_timer goes 1 -> 0: invuln <= 0 and go to ARMED.
  - Overlap is ignored in this state.
- OVER: terminal. Overlap and frame_tick are ignored, lives stays 0, dead stays 1.
- Without frame_tick, no register changes, except that hit always clears the cycle after it is set.
- lives never underflows, because the OVER transition happens at lives == 1.

## Timing
- Reset values:
  - state ARMED
  - hit 0, invuln 0, dead 0
  - lives LIVES_INIT
  - ovl_cnt 0, inv_timer 0
- Reset mid-operation, including in INVULN or OVER, returns every output to these values at the next edge and takes priority over frame_tick.
- Hit latency: if the confirming frame_tick is in cycle N, then hit, the new lives, and invuln or dead all become visible in cycle N+1. hit is high only in N+1.
- Invulnerability length: invuln stays high for exactly INVULN_FRAMES frame_ticks, counting from the first frame_tick after the hit. It falls in the cycle after the INVULN_FRAMES-th such tick.
- Back-to-back frame_ticks on consecutive cycles are legal and each is processed.
- Overlap in the same frame_tick that ends INVULN is not counted. Counting restarts from ARMED on the next frame_tick.
- spine_x going to 0, for example when the spine mover is reset, behaves as no overlap and drops COUNT back to ARMED.

## Test plan
- Reset, then 10 frame_ticks with spine_x=0 and Mario anywhere -> hit never pulses, lives=3, dead=0, invuln=0.
- spine_x=100, mario_x=110, mario_y=425, two consecutive frame_ticks -> hit high exactly one cycle after the second tick, lives=2, invuln=1.
- Same geometry for one tick, then mario_x=200 for one tick, then overlap for one tick -> no hit; the counter restarts.
- Edge cases with spine_x=100:
  - mario_x=120 -> no overlap.
  - mario_x=80 -> no overlap.
  - mario_x=119 -> overlap.
  - mario_y=420 -> no overlap (bottom edge 440).
- After a hit with INVULN_FRAMES=60 and overlap held continuously -> invuln deasserts after the 60th tick, and the next hit fires 2 ticks later; repeat until lives=0 -> dead=1 stays sticky, and further overlap produces no hit.
- Reset asserted while in INVULN with lives=1 -> next cycle lives=3, invuln=0, dead=0, state ARMED.

Source files
------------

// File: rtl/spine_hit.sv
// spine_hit: per-frame collision check between the floor spine and Mario,
// with multi-frame hit confirmation, life counting, an invulnerability
// window after each non-fatal hit, and a sticky game-over flag.
module spine_hit #(
  parameter int SPINE_W       = 20,
  parameter int SPINE_TOP_Y   = 440,
  parameter int MARIO_W       = 20,
  parameter int HIT_FRAMES    = 2,
  parameter int INVULN_FRAMES = 60,
  parameter int LIVES_INIT    = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [9:0] spine_x,
  input  logic [9:0] mario_x,
  input  logic [9:0] mario_y,
  output logic       hit,
  output logic       invuln,
  output logic [2:0] lives,
  output logic       dead
);

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    COUNT  = 2'd1,
    INVULN = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] ovl_cnt;
  logic [7:0] inv_timer;

  // 11-bit zero-extended geometry so the right/bottom edge sums never wrap.
  logic [10:0] spine_l;
  logic [10:0] spine_r;
  logic [10:0] mario_l;
  logic [10:0] mario_r;
  logic [10:0] mario_b;
  logic        overlap;
  logic        confirm;

  assign spine_l = {1'b0, spine_x};
  assign spine_r = spine_l + 11'(SPINE_W);
  assign mario_l = {1'b0, mario_x};
  assign mario_r = mario_l + 11'(MARIO_W);
  assign mario_b = {1'b0, mario_y} + 11'(MARIO_W);

  // Strict inequalities: boxes that only touch at an edge do not collide.
  assign overlap = (spine_x != 10'd0) &&
                   (mario_l < spine_r) &&
                   (spine_l < mario_r) &&
                   (mario_b > 11'(SPINE_TOP_Y));

  // A hit is confirmed on the tick that completes the required streak.
  assign confirm = frame_tick && overlap &&
                   (((state == ARMED) && (HIT_FRAMES == 1)) ||
                    ((state == COUNT) && ((ovl_cnt + 4'd1) == 4'(HIT_FRAMES))));

  // Collision/damage state machine with registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ARMED;
      hit       <= 1'b0;
      invuln    <= 1'b0;
      dead      <= 1'b0;
      lives     <= 3'(LIVES_INIT);
      ovl_cnt   <= 4'd0;
      inv_timer <= 8'd0;
    end else begin
      // hit is a single-cycle pulse regardless of frame_tick.
      hit <= 1'b0;
      if (confirm) begin
        hit     <= 1'b1;
        lives   <= lives - 3'd1;
        ovl_cnt <= 4'd0;
        if (lives == 3'd1) begin
          dead  <= 1'b1;
          state <= OVER;
        end else begin
          inv_timer <= 8'(INVULN_FRAMES);
          invuln    <= 1'b1;
          state     <= INVULN;
        end
      end else if (frame_tick) begin
        case (state)
          ARMED: begin
            if (overlap) begin
              ovl_cnt <= 4'd1;
              state   <= COUNT;
            end else begin
              ovl_cnt <= 4'd0;
            end
          end
          COUNT: begin
            if (overlap) begin
              ovl_cnt <= ovl_cnt + 4'd1;
            end else begin
              ovl_cnt <= 4'd0;
              state   <= ARMED;
            end
          end
          INVULN: begin
            // Overlap is ignored here; the streak restarts from ARMED.
            inv_timer <= inv_timer - 8'd1;
            if (inv_timer == 8'd1) begin
              invuln <= 1'b0;
              state  <= ARMED;
            end else begin
              invuln <= 1'b1;
            end
          end
          OVER: begin
            state <= OVER;
          end
          default: begin
            state <= ARMED;
          end
        endcase
      end else begin
        state <= state;
      end
    end
  end

endmodule

// File: tb/tb_spine_hit.sv
// Self-checking bench for spine_hit: directed scenarios plus randomized
// geometry/tick stimulus compared against a frame-level behavioural model.
module tb_spine_hit;

  localparam int SPINE_W       = 20;
  localparam int SPINE_TOP_Y   = 440;
  localparam int MARIO_W       = 20;
  localparam int HIT_FRAMES    = 2;
  localparam int INVULN_FRAMES = 60;
  localparam int LIVES_INIT    = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] spine_x = 10'd0;
  logic [9:0] mario_x = 10'd0;
  logic [9:0] mario_y = 10'd0;
  logic       hit;
  logic       invuln;
  logic [2:0] lives;
  logic       dead;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: lives, streak of overlapping frames, frames of
  // invulnerability still owed, and the resulting expected outputs.
  int         streak;
  int         inv_left;
  logic       m_hit;
  logic       m_inv;
  logic [2:0] m_lives;
  logic       m_dead;

  spine_hit #(
    .SPINE_W(SPINE_W), .SPINE_TOP_Y(SPINE_TOP_Y), .MARIO_W(MARIO_W),
    .HIT_FRAMES(HIT_FRAMES), .INVULN_FRAMES(INVULN_FRAMES), .LIVES_INIT(LIVES_INIT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
    .spine_x(spine_x), .mario_x(mario_x), .mario_y(mario_y),
    .hit(hit), .invuln(invuln), .lives(lives), .dead(dead)
  );

  always #5 Clk = ~Clk;

  function automatic bit overlaps(input int sx, input int mx, input int my);
    return (sx != 0) && (mx < sx + SPINE_W) && (sx < mx + MARIO_W) &&
           (my + MARIO_W > SPINE_TOP_Y);
  endfunction

  task automatic model_reset();
    streak = 0; inv_left = 0;
    m_hit = 1'b0; m_inv = 1'b0; m_dead = 1'b0;
    m_lives = 3'(LIVES_INIT);
  endtask

  task automatic model_edge(input bit ft);
    bit ov;
    ov = overlaps(int'(spine_x), int'(mario_x), int'(mario_y));
    m_hit = 1'b0;
    if (ft && !m_dead) begin
      if (inv_left > 0) begin
        inv_left--;
      end else if (ov) begin
        streak++;
        if (streak == HIT_FRAMES) begin
          m_hit = 1'b1;
          streak = 0;
          m_lives = m_lives - 3'd1;
          if (m_lives == 3'd0) m_dead = 1'b1;
          else inv_left = INVULN_FRAMES;
        end
      end else begin
        streak = 0;
      end
    end
    m_inv = (inv_left > 0);
  endtask

  // One clock edge with or without a frame tick; outputs sampled #1 later.
  task automatic step(input bit ft);
    frame_tick = ft;
    model_edge(ft);
    @(posedge Clk); #1;
    frame_tick = 1'b0;
  endtask

  task automatic reset_step(input bit ft);
    Reset = 1'b1;
    frame_tick = ft;
    model_reset();
    @(posedge Clk); #1;
    Reset = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic set_geo(input int sx, input int mx, input int my);
    spine_x = 10'(sx); mario_x = 10'(mx); mario_y = 10'(my);
  endtask

  task automatic test_reset();
    reset_step(1'b0);
    n_checks++;
    if ({hit, invuln, lives, dead} !== {1'b0, 1'b0, 3'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got hit=%b inv=%b lives=%0d dead=%b, want 0 0 3 0",
               hit, invuln, lives, dead);
    end
    for (int i = 0; i < 10; i++) begin
      set_geo(0, $urandom_range(0, 1023), $urandom_range(0, 1023));
      step(1'b1);
      n_checks++;
      if ({hit, invuln, lives, dead} !== {1'b0, 1'b0, 3'd3, 1'b0}) begin
        n_fail++;
        $display("FAIL inactive_spine[%0d]: got hit=%b inv=%b lives=%0d dead=%b, want 0 0 3 0",
                 i, hit, invuln, lives, dead);
      end
    end
  endtask

  task automatic test_basic_hit();
    reset_step(1'b0);
    set_geo(100, 110, 425);
    step(1'b1);
    n_checks++;
    if (hit !== 1'b0 || lives !== 3'd3) begin
      n_fail++;
      $display("FAIL basic_first_tick: got hit=%b lives=%0d, want 0 3", hit, lives);
    end
    step(1'b0);
    step(1'b1);
    n_checks++;
    if ({hit, invuln, lives, dead} !== {1'b1, 1'b1, 3'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_hit: got hit=%b inv=%b lives=%0d dead=%b, want 1 1 2 0",
               hit, invuln, lives, dead);
    end
    step(1'b0);
    n_checks++;
    if (hit !== 1'b0 || invuln !== 1'b1 || lives !== 3'd2) begin
      n_fail++;
      $display("FAIL hit_one_cycle: got hit=%b inv=%b lives=%0d, want 0 1 2", hit, invuln, lives);
    end
  endtask

  task automatic test_counter_restart();
    reset_step(1'b0);
    set_geo(100, 110, 425); step(1'b1);
    set_geo(100, 200, 425); step(1'b1);
    set_geo(100, 110, 425); step(1'b1);
    n_checks++;
    if (hit !== 1'b0 || lives !== 3'd3) begin
      n_fail++;
      $display("FAIL counter_restart: got hit=%b lives=%0d, want 0 3", hit, lives);
    end
    step(1'b1);
    n_checks++;
    if (hit !== 1'b1 || lives !== 3'd2) begin
      n_fail++;
      $display("FAIL restart_then_hit: got hit=%b lives=%0d, want 1 2", hit, lives);
    end
  endtask

  task automatic test_edges();
    int  mx_t [5] = '{120, 80, 119, 110, 81};
    int  my_t [5] = '{425, 425, 425, 420, 421};
    bit  exp_t[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      reset_step(1'b0);
      set_geo(100, mx_t[i], my_t[i]);
      step(1'b1);
      step(1'b1);
      n_checks++;
      if (hit !== exp_t[i] || hit !== m_hit) begin
        n_fail++;
        $display("FAIL edge[%0d] mx=%0d my=%0d: got hit=%b, want %b",
                 i, mx_t[i], my_t[i], hit, exp_t[i]);
      end
    end
  endtask

  task automatic test_full_game();
    int hits = 0;
    reset_step(1'b0);
    set_geo(100, 110, 425);
    for (int i = 0; i < 260; i++) begin
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      if (hit === 1'b1) hits++;
      n_checks++;
      if ({hit, invuln, lives, dead} !== {m_hit, m_inv, m_lives, m_dead}) begin
        n_fail++;
        $display("FAIL full_game[%0d]: got hit=%b inv=%b lives=%0d dead=%b, want %b %b %0d %b",
                 i, hit, invuln, lives, dead, m_hit, m_inv, m_lives, m_dead);
      end
    end
    n_checks++;
    if (hits != 3 || dead !== 1'b1 || lives !== 3'd0 || invuln !== 1'b0) begin
      n_fail++;
      $display("FAIL game_over: got hits=%0d dead=%b lives=%0d inv=%b, want 3 1 0 0",
               hits, dead, lives, invuln);
    end
  endtask

  task automatic test_back_to_back_invuln();
    int ticks = 0;
    reset_step(1'b0);
    set_geo(100, 110, 425);
    step(1'b1); step(1'b1);
    // Count consecutive ticks until invuln falls; must equal INVULN_FRAMES.
    while (invuln === 1'b1 && ticks < 300) begin
      step(1'b1);
      ticks++;
    end
    n_checks++;
    if (ticks != INVULN_FRAMES) begin
      n_fail++;
      $display("FAIL invuln_length: got %0d ticks, want %0d", ticks, INVULN_FRAMES);
    end
    step(1'b1);
    step(1'b1);
    n_checks++;
    if (hit !== 1'b1 || lives !== 3'd1) begin
      n_fail++;
      $display("FAIL second_hit_2_ticks: got hit=%b lives=%0d, want 1 1", hit, lives);
    end
  endtask

  task automatic test_reset_in_invuln();
    reset_step(1'b0);
    set_geo(100, 110, 425);
    for (int i = 0; i < 200 && !(m_lives == 3'd1 && m_inv); i++) step(1'b1);
    step(1'b1);
    n_checks++;
    if (lives !== 3'd1 || invuln !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state: got lives=%0d inv=%b, want 1 1", lives, invuln);
    end
    reset_step(1'b1);
    n_checks++;
    if ({hit, invuln, lives, dead} !== {1'b0, 1'b0, 3'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_in_invuln: got hit=%b inv=%b lives=%0d dead=%b, want 0 0 3 0",
               hit, invuln, lives, dead);
    end
    step(1'b1); step(1'b1);
    n_checks++;
    if (hit !== 1'b1 || lives !== 3'd2) begin
      n_fail++;
      $display("FAIL armed_after_reset: got hit=%b lives=%0d, want 1 2", hit, lives);
    end
  endtask

  task automatic test_random();
    reset_step(1'b0);
    for (int i = 0; i < 1500; i++) begin
      set_geo(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(90, 110),
              $urandom_range(70, 130), $urandom_range(410, 440));
      if ($urandom_range(0, 199) == 0) reset_step($urandom_range(0, 1) != 0);
      else step($urandom_range(0, 2) != 0);
      n_checks++;
      if ({hit, invuln, lives, dead} !== {m_hit, m_inv, m_lives, m_dead}) begin
        n_fail++;
        $display("FAIL random[%0d]: got hit=%b inv=%b lives=%0d dead=%b, want %b %b %0d %b",
                 i, hit, invuln, lives, dead, m_hit, m_inv, m_lives, m_dead);
      end
    end
  endtask

  initial begin
    model_reset();
    @(posedge Clk); #1;
    test_reset();
    test_basic_hit();
    test_counter_restart();
    test_edges();
    test_back_to_back_invuln();
    test_full_game();
    test_reset_in_invuln();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
